// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one single-port synchronous RAM between two requesters
module ram_arbiter #(
  parameter logic [31:0] ADDR_LOW  = 32'h00000000,
  parameter logic [31:0] ADDR_HIGH = 32'h00000fff,
  parameter logic        READ_ONLY = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_wdata_i,
  output logic        p0_gnt_o,
  output logic        p0_rvalid_o,
  output logic [31:0] p0_rdata_o,
  output logic        p0_err_o,
  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_wdata_i,
  output logic        p1_gnt_o,
  output logic        p1_rvalid_o,
  output logic [31:0] p1_rdata_o,
  output logic        p1_err_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic        ram_wren_o,
  input  logic [31:0] ram_data_i
);
  logic        last_q, last_d;
  logic        resp_v_q, resp_v_d;
  logic        resp_id_q, resp_id_d;
  logic        resp_err_q, resp_err_d;
  logic        any_gnt, sel_we, bad;
  logic [31:0] sel_addr, sel_wdata;
  // Grant the sole requester, or on a tie the port that was not served last; window check via one unsigned offset compare
  always_comb begin
    p0_gnt_o   = rst_n_i & p0_req_i & (~p1_req_i | last_q);
    p1_gnt_o   = rst_n_i & p1_req_i & (~p0_req_i | ~last_q);
    any_gnt    = p0_gnt_o | p1_gnt_o;
    sel_we     = p1_gnt_o ? p1_we_i : p0_we_i;
    sel_addr   = p1_gnt_o ? p1_addr_i : p0_addr_i;
    sel_wdata  = p1_gnt_o ? p1_wdata_i : p0_wdata_i;
    bad        = ((sel_addr - ADDR_LOW) > (ADDR_HIGH - ADDR_LOW)) | (sel_we & READ_ONLY);
    ram_addr_o = (any_gnt & ~bad) ? sel_addr : ADDR_LOW;
    ram_data_o = any_gnt ? sel_wdata : 32'h0;
    ram_wren_o = any_gnt & sel_we & ~bad;
    last_d     = any_gnt ? p1_gnt_o : last_q;
    resp_v_d   = any_gnt;
    resp_id_d  = p1_gnt_o;
    resp_err_d = any_gnt & bad;
  end
  // Response pipeline and round-robin history, captured at the grant edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q     <= 1'b1;
      resp_v_q   <= 1'b0;
      resp_id_q  <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      resp_v_q   <= resp_v_d;
      resp_id_q  <= resp_id_d;
      resp_err_q <= resp_err_d;
    end
  end
  assign p0_rvalid_o = resp_v_q & ~resp_id_q;
  assign p1_rvalid_o = resp_v_q & resp_id_q;
  assign p0_err_o    = p0_rvalid_o & resp_err_q;
  assign p1_err_o    = p1_rvalid_o & resp_err_q;
  assign p0_rdata_o  = (p0_rvalid_o & ~resp_err_q) ? ram_data_i : 32'h0;
  assign p1_rdata_o  = (p1_rvalid_o & ~resp_err_q) ? ram_data_i : 32'h0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with behavioural RAM models
module tb_ram_arbiter;
  localparam logic [31:0] HIGH = 32'h00000fff;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err, ram_wren;
  logic [31:0] p0_rdata, p1_rdata, ram_addr, ram_data, ram_q;
  logic ro_req = 0, ro_we = 0;
  logic [31:0] ro_addr = 0, ro_wdata = 0;
  logic ro_gnt, ro_rvalid, ro_err, ro_p1_gnt, ro_p1_rvalid, ro_p1_err, ro_wren;
  logic [31:0] ro_rdata, ro_p1_rdata, ro_ram_addr, ro_ram_data, ro_ram_q;
  logic [31:0] mem [4096];
  logic [31:0] mem2 [4096];
  logic [31:0] ref_mem [4096];
  logic mlast = 1'b1;
  int n_chk = 0, n_fail = 0;
  typedef struct { logic id; logic err; logic [31:0] data; } rsp_t;
  rsp_t q[$];

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_LOW(32'h0), .ADDR_HIGH(HIGH), .READ_ONLY(1'b0)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
    .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata), .p0_err_o(p0_err),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
    .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata), .p1_err_o(p1_err),
    .ram_addr_o(ram_addr), .ram_data_o(ram_data), .ram_wren_o(ram_wren), .ram_data_i(ram_q));

  ram_arbiter #(.ADDR_LOW(32'h0), .ADDR_HIGH(HIGH), .READ_ONLY(1'b1)) dut_ro (
    .clk_i(clk), .rst_n_i(rst_n),
    .p0_req_i(ro_req), .p0_we_i(ro_we), .p0_addr_i(ro_addr), .p0_wdata_i(ro_wdata),
    .p0_gnt_o(ro_gnt), .p0_rvalid_o(ro_rvalid), .p0_rdata_o(ro_rdata), .p0_err_o(ro_err),
    .p1_req_i(1'b0), .p1_we_i(1'b0), .p1_addr_i(32'h0), .p1_wdata_i(32'h0),
    .p1_gnt_o(ro_p1_gnt), .p1_rvalid_o(ro_p1_rvalid), .p1_rdata_o(ro_p1_rdata), .p1_err_o(ro_p1_err),
    .ram_addr_o(ro_ram_addr), .ram_data_o(ro_ram_data), .ram_wren_o(ro_wren), .ram_data_i(ro_ram_q));

  function automatic logic [31:0] pat(input int i);
    return 32'h5a5a0000 ^ i;
  endfunction

  // Registered-read RAMs that return the pre-write word on a write
  always @(posedge clk) begin
    ram_q <= mem[ram_addr[11:0]];
    if (ram_wren) mem[ram_addr[11:0]] <= ram_data;
    ro_ram_q <= mem2[ro_ram_addr[11:0]];
    if (ro_wren) mem2[ro_ram_addr[11:0]] <= ro_ram_data;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Response monitor: pops one expectation per cycle, otherwise requires silence
  always @(posedge clk) begin
    rsp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rvalid", {30'h0, p1_rvalid, p0_rvalid}, e.id ? 32'h2 : 32'h1);
      chk("err", e.id ? p1_err : p0_err, e.err);
      chk("rdata", e.id ? p1_rdata : p0_rdata, e.data);
    end else begin
      chk("idle_rvalid", {30'h0, p1_rvalid, p0_rvalid}, 32'h0);
      chk("idle_rdata", p0_rdata | p1_rdata, 32'h0);
    end
  end

  task automatic cyc(input logic r0, w0, input logic [31:0] a0, d0,
                     input logic r1, w1, input logic [31:0] a1, d1);
    logic g0, g1, id, we, bad;
    logic [31:0] a, d;
    @(negedge clk);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    #1;
    g0 = r0 & (!r1 | mlast);
    g1 = r1 & (!r0 | !mlast);
    chk("gnt0", p0_gnt, g0);
    chk("gnt1", p1_gnt, g1);
    if (g0 | g1) begin
      id = g1; we = id ? w1 : w0; a = id ? a1 : a0; d = id ? d1 : d0;
      bad = a > HIGH;
      chk("ram_wren", ram_wren, we & !bad);
      chk("ram_addr", ram_addr, bad ? 32'h0 : a);
      chk("ram_data", ram_data, d);
      q.push_back('{id, bad, bad ? 32'h0 : ref_mem[a[11:0]]});
      if (we && !bad) ref_mem[a[11:0]] = d;
      mlast = id;
    end else begin
      chk("idle_wren", ram_wren, 1'b0);
      chk("idle_addr", ram_addr, 32'h0);
      chk("idle_data", ram_data, 32'h0);
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic hit_reset();
    @(posedge clk);
    rst_n = 1'b0;
    q.delete();
    mlast = 1'b1;
    @(negedge clk);
    chk("rst_gnt", {30'h0, p1_gnt, p0_gnt}, 32'h0);
    chk("rst_wren", ram_wren, 1'b0);
    chk("rst_addr", ram_addr, 32'h0);
    p0_req = 0; p1_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = pat(i); mem2[i] = pat(i); ref_mem[i] = pat(i);
    end
    mem[5] = 32'hdeadbeef; ref_mem[5] = 32'hdeadbeef;
    p0_req = 1; p1_req = 1; p0_addr = 32'h20; p1_addr = 32'h30; p0_we = 1; p0_wdata = 32'h1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt", {30'h0, p1_gnt, p0_gnt}, 32'h0);
    chk("reset_wren", ram_wren, 1'b0);
    chk("reset_addr", ram_addr, 32'h0);
    chk("reset_data", ram_data, 32'h0);
    chk("reset_err", {30'h0, p1_err, p0_err}, 32'h0);
    p0_req = 0; p1_req = 0; p0_we = 0;
    rst_n = 1'b1;
    cyc(1, 0, 5, 0, 0, 0, 0, 0);
    idle();
    cyc(0, 0, 0, 0, 1, 1, 10, 32'h12345678);
    cyc(0, 0, 0, 0, 1, 0, 10, 0);
    idle();
    for (int i = 0; i < 6; i++) cyc(1, 0, 20, 0, 1, 0, 21, 0);
    idle();
    cyc(1, 0, HIGH + 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 32'hfffffff0, 32'h55);
    cyc(1, 0, HIGH, 0, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 4; i++) cyc(1, 0, i, 0, 0, 0, 0, 0);
    idle();
    cyc(1, 0, 7, 0, 0, 0, 0, 0);
    hit_reset();
    cyc(1, 0, 8, 0, 1, 0, 9, 0);
    idle();
    cyc(0, 0, 0, 0, 1, 0, 11, 0);
    hit_reset();
    cyc(1, 0, 12, 0, 1, 0, 13, 0);
    cyc(1, 0, 12, 0, 1, 0, 13, 0);
    idle();
    cyc(0, 0, 0, 0, 1, 0, 10, 0);
    idle();
    @(negedge clk);
    ro_req = 1; ro_we = 1; ro_addr = 3; ro_wdata = 32'hcafef00d;
    #1;
    chk("ro_gnt", ro_gnt, 1'b1);
    chk("ro_wren", ro_wren, 1'b0);
    chk("ro_addr", ro_ram_addr, 32'h0);
    @(negedge clk);
    ro_we = 0;
    chk("ro_wr_rvalid", ro_rvalid, 1'b1);
    chk("ro_wr_err", ro_err, 1'b1);
    chk("ro_wr_rdata", ro_rdata, 32'h0);
    #1;
    chk("ro_rd_addr", ro_ram_addr, 32'h3);
    @(negedge clk);
    ro_req = 0;
    chk("ro_rd_rvalid", ro_rvalid, 1'b1);
    chk("ro_rd_err", ro_err, 1'b0);
    chk("ro_rd_rdata", ro_rdata, pat(3));
    repeat (3) @(negedge clk);
    chk("ro_idle", ro_rvalid, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter that shares one single-port synchronous `ram` instance between two requesters: port 0 (instruction fetch) and port 1 (load/store). It accepts at most one access per cycle and drives the RAM address, write data and write enable. It returns read data one cycle after the grant, matching the RAM's registered read. Accesses outside the configured word-address window, and writes to a read-only instance, are rejected with an error response and never reach the RAM.

## Interface

Parameters:
- `ADDR_LOW`, default 32'h00000000: lowest valid word address; must match the attached `ram`'s `addr_low`.
- `ADDR_HIGH`, default 32'h00000fff: highest valid word address; must match the attached `ram`'s `addr_high`.
- `READ_ONLY`, default 1'b0: when 1, every write request is rejected with an error.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `p0_req_i` / `p1_req_i`  in  1  access request; held high with stable command until the matching grant.
- `p0_we_i` / `p1_we_i`  in  1  1 = write, 0 = read.
- `p0_addr_i` / `p1_addr_i`  in  32  word address.
- `p0_wdata_i` / `p1_wdata_i`  in  32  write data.
- `p0_gnt_o` / `p1_gnt_o`  out  1  combinational grant; the command is consumed this cycle.
- `p0_rvalid_o` / `p1_rvalid_o`  out  1  response strobe, exactly one cycle after the grant.
- `p0_rdata_o` / `p1_rdata_o`  out  32  response data, valid while `rvalid` is high.
- `p0_err_o` / `p1_err_o`  out  1  response is an error; qualified by `rvalid`.
- `ram_addr_o`  out  32  RAM address.
- `ram_data_o`  out  32  RAM write data.
- `ram_wren_o`  out  1  RAM write enable.
- `ram_data_i`  in  32  RAM registered read data (`data_o`).

## Operation

- Arbitration: combinational, at most one grant per cycle.
  - If exactly one request is high, that port is granted.
  - If both are high, the grant goes to the port not recorded in the `last` register.
  - `last` updates to the granted port on every grant.
  - After reset `last` = 1, so port 0 wins the first tie.
- Range check on the granted command: `bad` = (addr < `ADDR_LOW`) or (addr > `ADDR_HIGH`) or (we and `READ_ONLY`).
- RAM drive in the grant cycle:
  - `ram_addr_o` = granted address; `ram_data_o` = granted wdata.
  - `ram_wren_o` = granted we and not `bad`.
  - With no grant: `ram_addr_o` = `ADDR_LOW`, `ram_data_o` = 0, `ram_wren_o` = 0.
  - With `bad`: the address is forced to `ADDR_LOW` and no write is issued.
- Response pipeline registers, captured at the grant edge:
  - `resp_v` — a response is pending.
  - `resp_id` — which port it belongs to.
  - `resp_err` — the `bad` flag.
- Response outputs:
  - `pX_rvalid_o` = `resp_v` and (`resp_id` == X); `pX_err_o` = `pX_rvalid_o` and `resp_err`.
  - `pX_rdata_o` = `ram_data_i` when the response is good, 0 when it is an error; 0 whenever `rvalid` is low.
  - Writes also produce a response (acknowledge). Their rdata is the pre-write word, because the RAM reads before it writes.
- Dataflow is fully pipelined: a new grant may occur in the same cycle as the previous response, giving one access per cycle sustained.
- Reset asserted mid-access: the pending response is discarded (no `rvalid`) and `last` returns to 1. A RAM write already sampled is not undone.

## Timing

- Reset values: all `gnt`, `rvalid`, `err`, `rdata` = 0; `ram_wren_o` = 0; `ram_addr_o` = `ADDR_LOW`; `ram_data_o` = 0; `resp_v` = 0; `last` = 1.
- Grants and `ram_*` outputs are forced idle while `rst_n_i` is low.
- Cycle T: grant given, RAM samples address and write data at the end of T.
- Cycle T+1: `rvalid` high for one cycle with rdata (`ram_data_i`) or err.
- Request-to-grant latency:
  - 0 cycles when uncontended.
  - At most 1 extra cycle under continuous contention; with both requests held, grants alternate 0,1,0,1.
- Combinational paths: `req`, `we` and `addr` to `gnt` and `ram_*` (no registers on this path). `ram_data_i` to `rdata`.

## Test plan

- Reset then single read: memory[5] = 32'hDEADBEEF, p0 reads addr 5 → `p0_gnt_o` high in the same cycle; next cycle `p0_rvalid_o` = 1, `p0_rdata_o` = 32'hDEADBEEF, `p0_err_o` = 0.
- Write then read: p1 writes 32'h12345678 to addr 10, then reads addr 10 → the write response returns the old word; the read returns 32'h12345678.
- Contention: both ports request continuously for 6 cycles → grant order p0,p1,p0,p1,p0,p1; each `rvalid` lands on the correct port one cycle after its grant.
- Range error: p0 reads addr `ADDR_HIGH`+1 → `ram_wren_o` = 0, `ram_addr_o` = `ADDR_LOW`; next cycle `p0_rvalid_o` = 1, `p0_err_o` = 1, rdata = 0. With `READ_ONLY` = 1, a write to addr 3 also errors and memory[3] is unchanged.
- Back-to-back pipelining: p0 reads addrs 0,1,2,3 on consecutive cycles → four consecutive `rvalid` pulses carrying memory[0..3].
- Mid-access reset: assert `rst_n_i` low asynchronously in the cycle after a p1 grant → no `p1_rvalid_o`; after release, a tie is granted to p0 first.
